// File: rtl/pipelined_rca.sv
// pipelined_rca: valid/ready pipelined ripple-carry adder/subtractor, one SEG-bit ripple segment per stage
module pipelined_rca #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int NSTG = WIDTH / SEG;
  logic             w_en;
  logic             w_acc;
  logic [WIDTH-1:0] w_b;
  logic             w_cin;
  logic             w_ovf;
  logic [NSTG-1:0]  w_co;
  logic [NSTG-1:0]  r_v;
  logic [NSTG-1:0]  r_c;
  logic             r_ovf;
  assign out_valid = r_v[NSTG-1];
  assign w_en      = !out_valid || out_ready;
  assign in_ready  = w_en;
  assign w_acc     = in_valid && w_en;
  assign w_b       = sub ? ~in_2 : in_2;
  assign w_cin     = sub | c_in;
  assign c_out     = r_c[NSTG-1];
  assign ovf       = r_ovf;
  assign sum       = g_stg[NSTG-1].r_s;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v   <= '0;
      r_c   <= '0;
      r_ovf <= 1'b0;
    end else if (w_en) begin
      r_v   <= (r_v << 1) | NSTG'(w_acc);
      r_c   <= w_co;
      r_ovf <= w_ovf;
    end
  end
  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int RW = WIDTH - k * SEG;
    logic [RW-1:0]         w_a;
    logic [RW-1:0]         w_bb;
    logic                  w_ci;
    logic [SEG-1:0]        w_sl;
    logic [(k+1)*SEG-1:0]  r_s;
    assign {w_co[k], w_sl} = {1'b0, w_a[SEG-1:0]} + {1'b0, w_bb[SEG-1:0]} + (SEG+1)'(w_ci);
    if (k == 0) begin : g_in
      assign w_a  = in_1;
      assign w_bb = w_b;
      assign w_ci = w_cin;
      always_ff @(posedge clk) begin
        if (!rst_n) r_s <= '0;
        else if (w_en) r_s <= w_sl;
      end
    end else begin : g_in
      assign w_a  = g_stg[k-1].g_op.r_a;
      assign w_bb = g_stg[k-1].g_op.r_b;
      assign w_ci = r_c[k-1];
      always_ff @(posedge clk) begin
        if (!rst_n) r_s <= '0;
        else if (w_en) r_s <= {w_sl, g_stg[k-1].r_s};
      end
    end
    // upper operand slices ride along until their segment's carry arrives
    if (k < NSTG - 1) begin : g_op
      logic [RW-SEG-1:0] r_a;
      logic [RW-SEG-1:0] r_b;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en) begin
          r_a <= w_a[RW-1:SEG];
          r_b <= w_bb[RW-1:SEG];
        end
      end
    end
    if (k == NSTG - 1) begin : g_ovf
      assign w_ovf = w_a[SEG-1] ^ w_bb[SEG-1] ^ w_sl[SEG-1] ^ w_co[k];
    end
  end
endmodule

// File: tb/tb_pipelined_rca.sv
// tb_pipelined_rca: randomized and directed checks of pipelined_rca against an arithmetic reference model
module tb_pipelined_rca;
  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [15:0] in_1 = 0;
  logic [15:0] in_2 = 0;
  logic        c_in = 0;
  logic        sub = 0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [15:0] sum;
  logic        c_out;
  logic        ovf;
  int          checks = 0;
  int          failures = 0;
  int          n_out = 0;
  exp_t        q[$];
  logic        hold_pend = 0;
  exp_t        held;
  logic        rnd_done = 0;
  pipelined_rca #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_1(in_1), .in_2(in_2), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
    int unsigned ua = a;
    int unsigned ub = b;
    int unsigned r;
    exp_t e;
    if (sb) begin
      e.s = 16'(ua - ub);
      e.c = ua >= ub;
      e.o = (a[15] != b[15]) && (e.s[15] != a[15]);
    end else begin
      r = ua + ub + 32'(ci);
      e.s = r[15:0];
      e.c = r[16];
      e.o = (a[15] == b[15]) && (e.s[15] != a[15]);
    end
    return e;
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      hold_pend = 0;
    end else begin
      if (hold_pend && out_valid) begin
        check("hold_sum", sum, held.s);
        check("hold_cout", c_out, held.c);
        check("hold_ovf", ovf, held.o);
      end
      if (out_valid) begin
        check("out_has_model", q.size() != 0, 1);
        if (q.size() != 0) begin
          check("sum", sum, q[0].s);
          check("c_out", c_out, q[0].c);
          check("ovf", ovf, q[0].o);
          if (out_ready) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
      hold_pend = out_valid && !out_ready;
      held = '{s: sum, c: c_out, o: ovf};
      if (in_valid && in_ready) q.push_back(model(in_1, in_2, c_in, sub));
    end
  end
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
    int n = 0;
    logic acc;
    in_1 = a; in_2 = b; c_in = ci; sub = sb; in_valid = 1;
    do begin
      @(negedge clk);
      acc = in_ready;
      n++;
      @(posedge clk);
      #1;
    end while (!acc && n < 200);
    if (!acc) check("accept_timeout", 0, 1);
    in_valid = 0;
  endtask
  task automatic do_one(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb,
                        input logic [15:0] es, input logic ec, input logic eo);
    int lat = 0;
    check("model_pin", model(a, b, ci, sb), {es, ec, eo});
    send(a, b, ci, sb);
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    check("latency", lat, 3);
    check("lit_sum", sum, es);
    check("lit_cout", c_out, ec);
    check("lit_ovf", ovf, eo);
    @(negedge clk);
    check("one_cycle_valid", out_valid, 0);
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, q.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", c_out, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    do_one(16'h1234, 16'h1111, 0, 0, 16'h2345, 0, 0);
    do_one(16'hFFFF, 16'h0000, 1, 0, 16'h0000, 1, 0);
    do_one(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
    do_one(16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0);
    do_one(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);
    do_one(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
    fork
      for (int i = 0; i < 8; i++) send(16'(i), 16'(32'h100 * i), 0, 0);
      begin
        int n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid && n < 50);
        for (int i = 0; i < 8; i++) begin
          if (i > 0) @(negedge clk);
          check("stream_valid", out_valid, 1);
          check("stream_sum", sum, 32'h0101 * i);
        end
        @(negedge clk);
        check("stream_end", out_valid, 0);
      end
    join
    @(posedge clk);
    #1;
    base = n_out;
    fork
      for (int i = 0; i < 6; i++) send(16'(32'h0111 * (i + 1)), 16'(32'h1001 * i), 0, 0);
      begin
        int n = 0;
        do begin
          @(posedge clk);
          #2;
          n++;
        end while (!out_valid && n < 50);
        out_ready = 0;
        repeat (5) begin
          @(posedge clk);
          #2;
        end
        out_ready = 1;
      end
    join
    drain("bp_drain");
    check("bp_count", n_out - base, 6);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), 0, 0);
    rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_in_ready", in_ready, 1);
    begin
      int stale = 0;
      repeat (10) begin
        @(negedge clk);
        if (out_valid) stale++;
      end
      check("no_stale", stale, 0);
    end
    @(posedge clk);
    #1;
    base = n_out;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1;
      end
      while (!rnd_done) begin
        @(posedge clk);
        #2;
        out_ready = $urandom_range(0, 3) != 0;
      end
    join
    out_ready = 1;
    drain("rnd_drain");
    check("rnd_count", n_out - base, 300);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
